// File: rtl/gen_padded_multi.sv
// SHA256 multi-block padder: streams a message from byte SRAM and presents each
// padded 512-bit block to the compression core over a valid/ready handshake.
module gen_padded_multi #(
  parameter int MAX_MESSAGE_LENGTH = 256,
  parameter int ADDR_WIDTH = (MAX_MESSAGE_LENGTH > 1) ? $clog2(MAX_MESSAGE_LENGTH) : 1,
  parameter int LEN_WIDTH  = $clog2(MAX_MESSAGE_LENGTH + 1),
  parameter int BLK_WIDTH  = $clog2((MAX_MESSAGE_LENGTH + 72) / 64 + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  main_go_sig,
  input  logic [LEN_WIDTH-1:0]  msg_len,
  input  logic [7:0]            msg_mem_data,
  input  logic                  blk_ready,
  output logic                  regop_msg_mem_en,
  output logic [ADDR_WIDTH-1:0] regop_msg_mem_addr,
  output logic [511:0]          regop_pad_reg,
  output logic                  regop_pad_rdy,
  output logic                  regop_pad_last,
  output logic [BLK_WIDTH-1:0]  regop_blk_idx,
  output logic                  regop_busy
);

  localparam int IW = LEN_WIDTH + BLK_WIDTH + 8;

  typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [BLK_WIDTH-1:0]  lastIdx_q, lastIdx_d;
  logic [BLK_WIDTH-1:0]  blk_q, blk_d;
  logic [5:0]            pos_q, pos_d;
  logic                  issue_q, issue_d;
  logic                  memEn_q, memEn_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic                  s1Valid_q, s1Valid_d, s2Valid_q, s2Valid_d;
  logic [5:0]            s1Pos_q, s1Pos_d, s2Pos_q, s2Pos_d;
  logic                  s1IsMsg_q, s1IsMsg_d, s2IsMsg_q, s2IsMsg_d;
  logic [7:0]            s1Byte_q, s1Byte_d, s2Byte_q, s2Byte_d;
  logic [511:0]          pad_q, pad_d;
  logic                  rdy_q, rdy_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;

  logic [IW-1:0]         gIdx, lenExt;
  logic [63:0]           lenBits;
  logic                  isMsg;
  logic [7:0]            issueByte;
  logic [LEN_WIDTH-1:0]  lenClamp;

  // Classify the byte at the issue pointer: message, 0x80 marker, length field or zero.
  always_comb begin
    gIdx      = IW'({blk_q, pos_q});
    lenExt    = IW'(len_q);
    lenBits   = 64'(len_q) << 3;
    isMsg     = gIdx < lenExt;
    issueByte = 8'h00;
    if (gIdx == lenExt) begin
      issueByte = 8'h80;
    end else if (blk_q == lastIdx_q && pos_q >= 6'd56) begin
      issueByte = lenBits[{~pos_q[2:0], 3'b000} +: 8];
    end
    lenClamp = (IW'(msg_len) > IW'(MAX_MESSAGE_LENGTH)) ? LEN_WIDTH'(MAX_MESSAGE_LENGTH) : msg_len;
  end

  // Every position travels a two-stage pipe so SRAM bytes and generated bytes land alike.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    lastIdx_d = lastIdx_q;
    blk_d     = blk_q;
    pos_d     = pos_q;
    issue_d   = issue_q;
    memEn_d   = 1'b0;
    memAddr_d = memAddr_q;
    s1Valid_d = 1'b0;
    s1Pos_d   = s1Pos_q;
    s1IsMsg_d = s1IsMsg_q;
    s1Byte_d  = s1Byte_q;
    s2Valid_d = s1Valid_q;
    s2Pos_d   = s1Pos_q;
    s2IsMsg_d = s1IsMsg_q;
    s2Byte_d  = s1Byte_q;
    pad_d     = pad_q;
    rdy_d     = rdy_q;
    last_d    = last_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (main_go_sig) begin
          state_d   = FILL;
          len_d     = lenClamp;
          lastIdx_d = BLK_WIDTH'((IW'(lenClamp) + IW'(8)) >> 6);
          blk_d     = '0;
          pos_d     = '0;
          issue_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      FILL: begin
        if (issue_q) begin
          s1Valid_d = 1'b1;
          s1Pos_d   = pos_q;
          s1IsMsg_d = isMsg;
          s1Byte_d  = issueByte;
          memEn_d   = isMsg;
          if (isMsg) begin
            memAddr_d = ADDR_WIDTH'(gIdx);
          end
          pos_d = pos_q + 6'd1;
          if (pos_q == 6'd63) begin
            issue_d = 1'b0;
          end
        end
        if (s2Valid_q) begin
          pad_d[{~s2Pos_q, 3'b000} +: 8] = s2IsMsg_q ? msg_mem_data : s2Byte_q;
          if (s2Pos_q == 6'd63) begin
            state_d = PRESENT;
            rdy_d   = 1'b1;
            last_d  = (blk_q == lastIdx_q);
          end
        end
      end
      PRESENT: begin
        if (blk_ready) begin
          rdy_d  = 1'b0;
          last_d = 1'b0;
          if (last_q) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            blk_d   = blk_q + BLK_WIDTH'(1);
            pos_d   = '0;
            issue_d = 1'b1;
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      lastIdx_q <= '0;
      blk_q     <= '0;
      pos_q     <= '0;
      issue_q   <= 1'b0;
      memEn_q   <= 1'b0;
      memAddr_q <= '0;
      s1Valid_q <= 1'b0;
      s1Pos_q   <= '0;
      s1IsMsg_q <= 1'b0;
      s1Byte_q  <= '0;
      s2Valid_q <= 1'b0;
      s2Pos_q   <= '0;
      s2IsMsg_q <= 1'b0;
      s2Byte_q  <= '0;
      pad_q     <= '0;
      rdy_q     <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      lastIdx_q <= lastIdx_d;
      blk_q     <= blk_d;
      pos_q     <= pos_d;
      issue_q   <= issue_d;
      memEn_q   <= memEn_d;
      memAddr_q <= memAddr_d;
      s1Valid_q <= s1Valid_d;
      s1Pos_q   <= s1Pos_d;
      s1IsMsg_q <= s1IsMsg_d;
      s1Byte_q  <= s1Byte_d;
      s2Valid_q <= s2Valid_d;
      s2Pos_q   <= s2Pos_d;
      s2IsMsg_q <= s2IsMsg_d;
      s2Byte_q  <= s2Byte_d;
      pad_q     <= pad_d;
      rdy_q     <= rdy_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  assign regop_msg_mem_en   = memEn_q;
  assign regop_msg_mem_addr = memAddr_q;
  assign regop_pad_reg      = pad_q;
  assign regop_pad_rdy      = rdy_q;
  assign regop_pad_last     = last_q;
  assign regop_blk_idx      = blk_q;
  assign regop_busy         = busy_q;

endmodule
